// File: rtl/fp16_systolic_skew_feeder_if.sv
// Beat stream from the activation buffer into the skew feeder.
// One FP16 column vector per beat; lane r sits at bits [16r+15:16r].
interface fp16_systolic_skew_feeder_if #(
  parameter int unsigned ROWS = 4
);
  localparam int unsigned DATA_W = 16 * ROWS;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fp16_systolic_skew_feeder.sv
// Skewed FP16 activation feeder for the left edge of a systolic MAC array.
// Optional macro SKEW_FEEDER_PERF_EN adds a saturating stall_cycles counter port.
module fp16_systolic_skew_feeder #(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned KLEN_W      = 8,
  parameter int unsigned FLUSH_EXTRA = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [KLEN_W-1:0]         k_len,
  fp16_systolic_skew_feeder_if.slave bus,
  output logic [16*ROWS-1:0]        a_out,
  output logic                      pe_enable,
  output logic [ROWS-1:0]           acc_clear,
  output logic                      busy,
  output logic                      done
`ifdef SKEW_FEEDER_PERF_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);
  localparam int unsigned LANE_W  = 16;
  localparam int unsigned DATA_W  = LANE_W * ROWS;
  localparam int unsigned FLUSH_N = ROWS + 1 + FLUSH_EXTRA;
  localparam int unsigned FCNT_W  = $clog2(FLUSH_N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t              state;
  logic [KLEN_W-1:0]   k_cap;
  logic [KLEN_W-1:0]   beat_cnt;
  logic [FCNT_W-1:0]   flush_cnt;
  logic                advance;
  logic                tile_fresh;
  logic                clr_seed;
  logic [DATA_W-1:0]   feed;

  // The array only moves on an accepted beat or a flush cycle; stalls freeze everything.
  assign advance      = ((state == LOAD) && bus.in_valid) || (state == FLUSH);
  assign pe_enable    = advance;
  assign bus.in_ready = (state == LOAD);
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign feed         = (state == LOAD) ? bus.in_data : '0;

  // Tile sequencer: load k_len beats, flush FLUSH_N zero edges, one-cycle done.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k_cap     <= '0;
      beat_cnt  <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_cap     <= k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            state     <= (k_len == '0) ? DONE : LOAD;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            beat_cnt <= beat_cnt + KLEN_W'(1);
            if (beat_cnt == k_cap - KLEN_W'(1)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + FCNT_W'(1);
          if (flush_cnt == FCNT_W'(FLUSH_N - 1)) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Clear token: seeded at E_0, reaches acc_clear[0] at E_1, then walks down one row per edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_fresh <= 1'b0;
      clr_seed   <= 1'b0;
      acc_clear  <= '0;
    end else if ((state == IDLE) && start) begin
      tile_fresh <= 1'b1;
      clr_seed   <= 1'b0;
      acc_clear  <= '0;
    end else if (advance) begin
      tile_fresh   <= 1'b0;
      clr_seed     <= tile_fresh;
      acc_clear[0] <= clr_seed;
      for (int r = 1; r < ROWS; r++) begin
        acc_clear[r] <= acc_clear[r-1];
      end
    end
  end

  // Lane r: r delay stages plus the output stage, packed LSB-first as a shift chain.
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    localparam int unsigned CW = LANE_W * (r + 1);
    logic [CW-1:0] chain;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        chain <= '0;
      end else if (advance) begin
        chain <= CW'({chain, feed[LANE_W*r +: LANE_W]});
      end
    end

    assign a_out[LANE_W*r +: LANE_W] = chain[LANE_W*r +: LANE_W];
  end

`ifdef SKEW_FEEDER_PERF_EN
  // Starved LOAD cycles for the current tile, saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if ((state == IDLE) && start) begin
      stall_cycles <= '0;
    end else if ((state == LOAD) && !bus.in_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fp16_systolic_skew_feeder.md
Name: fp16_systolic_skew_feeder

Overview:
- Transmit side of the FP16 MAC processing-element (PE) interface.
- Accepts one FP16 column vector per beat from the activation buffer and drives skewed per-row activation streams into the left edge of the systolic array.
- Generates the shared PE enable and per-row accumulator-clear strobes, aligned to the PE's one-stage multiplier pipeline.
- Runs one tile per start: load k_len beats, flush with +0.0, then pulse done.

Parameters:
- ROWS, 4: number of array rows, i.e. FP16 lanes per beat.
- KLEN_W, 8: width of k_len and the beat counter.
- FLUSH_EXTRA, 4: extra zero-flush edges for propagation across array columns.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin tile; sampled only in IDLE.
- k_len  in  KLEN_W  beats in tile; captured when start is accepted.
- in_valid  in  1  in_data valid.
- in_ready  out  1  feeder accepts a beat.
- in_data  in  16*ROWS  lane r at bits [16r+15:16r], FP16.
- a_out  out  16*ROWS  skewed activations to array rows, lane layout as in_data.
- pe_enable  out  1  array advance strobe (drives PE enable).
- acc_clear  out  ROWS  per-row accumulator clear, to column-0 PE of each row.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle tile-complete pulse.

Behaviour:
- Reset is synchronous on rst_n=0 at a clk edge, and applies mid-operation too. Reset values:
  - state=IDLE
  - all skew registers, a_out, acc_clear: 0
  - in_ready, pe_enable, busy, done: 0
  - counters: 0
- States:
  - IDLE: start=1 with k_len>0 → LOAD (capture k_len). start=1 with k_len=0 → DONE directly; no pe_enable issued.
  - LOAD: in_ready=1 (combinational from state). A beat is accepted when in_valid&&in_ready. After the k_len-th accepted beat → FLUSH.
  - FLUSH: in_ready=0. pe_enable=1 every cycle; lane 0 is fed 16'h0000. After ROWS+1+FLUSH_EXTRA flush edges → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Advance: advance = (LOAD && in_valid) || FLUSH.
  - pe_enable = advance, combinational.
  - With advance=0 (LOAD, in_valid=0), all skew, acc_clear and counter registers hold. The array is frozen; no bubbles are inserted into the data stream.
- Skew, with E_n = n-th advancing edge of the tile (E_0 = first accepted beat):
  - Lane r has an r-deep delay chain plus an output register.
  - Beat j lane r appears on a_out lane r from E_{j+r} until E_{j+r+1}.
  - Lanes not yet reached hold 16'h0000.
- acc_clear[r]: registered; high during the cycle preceding E_{r+2}, exactly one enabled cycle wide. This lets the row-r PE load its first product (registered at E_{r+1}) at E_{r+2}. acc_clear bits are otherwise 0; they hold while stalled.
- Final product of row ROWS-1 accumulates at E_{k_len+ROWS}. The flush count covers this plus FLUSH_EXTRA.
- No arithmetic on data; FP16 values pass bit-exact, including NaN, Inf and -0.
- Ignored inputs:
  - start while busy is ignored.
  - in_valid outside LOAD is ignored; in_data is not consumed.
  - A k_len change after capture has no effect.

Optional Feature:
- Macro: SKEW_FEEDER_PERF_EN.
- Defined:
  - Adds output port stall_cycles [31:0].
  - Counts LOAD cycles with in_valid=0; cleared at tile start.
  - Saturates at 32'hFFFFFFFF; holds value after done; 0 on reset.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- ROWS=4, FLUSH_EXTRA=0, k_len=3, in_valid held high, beats lane values 16'h3C00/16'h4000/16'h4200:
  - in_ready high exactly 3 cycles, then 5 flush cycles.
  - done pulses once on the cycle after the 8th advancing edge.
  - a_out lane 3 shows 16'h3C00 only after E_3.
- Same tile with in_valid low for 2 cycles after beat 0:
  - pe_enable low those 2 cycles.
  - a_out and acc_clear frozen.
  - Final lane sequence identical to the unstalled run; PERF build reports stall_cycles=2.
- acc_clear check, k_len=1: acc_clear[r] is asserted one enabled cycle before E_{r+2}, for r=0..3, each exactly one enabled cycle wide.
- start with k_len=0:
  - busy for 1 cycle; done pulses next cycle.
  - pe_enable never asserted.
  - a_out remains 16'h0000.
- rst_n=0 asserted mid-LOAD after 2 beats:
  - Next edge: state IDLE, a_out=0, acc_clear=0, in_ready=0, busy=0.
  - A subsequent start with k_len=2 runs a clean tile.
- start pulsed during FLUSH and in_valid pulsed in IDLE: both ignored; no beat consumed and the tile length is unchanged.
